resync_debounce: RTL and testbench

RESYNC_DEBOUNCE -- requirements
Module: resync_debounce

---
 rtl/resync_pkg.sv | 14 +
 rtl/resync_debounce_chan.sv | 84 ++++++++
 rtl/resync_debounce.sv | 46 ++++
 tb/tb_resync_debounce.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/resync_pkg.sv
// Shared constants for the resync_debounce block: default synchroniser depth,
// default debounce length, and the per-channel stability counter width.
package resync_pkg;

  localparam int DEF_STAGES          = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // Width needed to hold every count value 0..n (the counter never reaches n,
  // but sizing for n+1 states keeps n=1 at a legal 1-bit width).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : resync_pkg

// File: rtl/resync_debounce_chan.sv
// One channel of resync_debounce: a STAGES-deep synchroniser followed by a
// stability counter that only lets the output follow the synchronised level
// once it has disagreed with the output for DEBOUNCE_CYCLES consecutive edges.
// Build option: RESYNC_DEBOUNCE_EDGE_EN builds registered rise/fall pulses;
// without it the pulse outputs are tied low and no pulse registers exist.
module resync_debounce_chan
  import resync_pkg::*;
#(
  parameter int   STAGES          = DEF_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0] sync_q;
  logic              s;
  logic              q_q, q_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              at_last;

  assign s       = sync_q[STAGES-1];
  assign at_last = (cnt_q == CNT_LAST);
  assign q_o     = q_q;

  // Synchroniser chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {STAGES{RESET_BIT}};
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  // Debounce decision: agree -> clear count; disagree -> count, or commit
  // the new level on the last count (counter is cleared, so it never wraps).
  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    if (s != q_q) begin
      if (at_last) q_d   = s;
      else         cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounced level and stability counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q   <= RESET_BIT;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef RESYNC_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses are registered alongside q_q so they coincide with the output
  // change; s differs from q_q when committing, so only one can be set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= (s != q_q) && at_last &&  s;
      fall_q <= (s != q_q) && at_last && !s;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule : resync_debounce_chan

// File: rtl/resync_debounce.sv
// resync_debounce: WIDTH independent synchronise-and-debounce channels.
// Build option: RESYNC_DEBOUNCE_EDGE_EN enables the rise/fall pulse outputs;
// when undefined those ports stay present but are constant 0.
module resync_debounce
  import resync_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               STAGES          = DEF_STAGES,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Reject configurations that cannot synchronise or debounce.
  generate
    if (STAGES < 2) begin : g_bad_stages
      $fatal(1, "resync_debounce: STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $fatal(1, "resync_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  // One fully independent channel per data bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    resync_debounce_chan #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_chan (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (data_in[i]),
      .q_o    (data_out[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

endmodule : resync_debounce

// File: tb/tb_resync_debounce.sv
// Directed bench for resync_debounce (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4).
// Edge 0 is the posedge right after which a stimulus is launched; a stable
// change then shows on data_out at edge 6. Pulse expectations collapse to 0
// when RESYNC_DEBOUNCE_EDGE_EN is not defined.
module tb_resync_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [3:0] rise;
  logic [3:0] fall;

`ifdef RESYNC_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  resync_debounce #(
    .WIDTH           (4),
    .STAGES          (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (4'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .rise     (rise),
    .fall     (fall)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulse(input logic [3:0] v);
    return EDGE_EN ? v : 4'h0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [3:0] exp_out);
    check_eq({tag, ".out"},  data_out, exp_out);
    check_eq({tag, ".rise"}, rise,     4'h0);
    check_eq({tag, ".fall"}, fall,     4'h0);
  endtask

  // Launch din at edge 0 and check edges 1..8 against hand-derived values.
  task automatic run_vec(input string tag, input logic [3:0] prev,
                         input logic [3:0] din, input logic [3:0] r, input logic [3:0] f);
    logic [3:0] e_out;
    data_in = din;
    for (int e = 1; e <= 8; e++) exp_q.push_back(e >= 6 ? din : prev);
    for (int e = 1; e <= 8; e++) begin
      step();
      e_out = exp_q.pop_front();
      check_eq($sformatf("%s.out@%0d", tag, e),  data_out, e_out);
      check_eq($sformatf("%s.rise@%0d", tag, e), rise, (e == 6) ? pulse(r) : 4'h0);
      check_eq($sformatf("%s.fall@%0d", tag, e), fall, (e == 6) ? pulse(f) : 4'h0);
    end
  endtask

  typedef struct {
    logic [3:0] din;
    logic [3:0] out;
    logic [3:0] r;
    logic [3:0] f;
  } vec_t;

  // Hand-computed: each entry starts from the previous entry's out.
  vec_t vecs[8] = '{
    '{4'h1, 4'h1, 4'h1, 4'h0},   // clean single-channel step
    '{4'h8, 4'h8, 4'h8, 4'h1},   // swap channels
    '{4'h4, 4'h4, 4'h4, 4'h8},   // simultaneous rise/fall on different bits
    '{4'h0, 4'h0, 4'h0, 4'h4},
    '{4'hF, 4'hF, 4'hF, 4'h0},   // all channels rise together
    '{4'hA, 4'hA, 4'h0, 4'h5},
    '{4'h5, 4'h5, 4'h5, 4'hA},   // every channel toggles
    '{4'h0, 4'h0, 4'h0, 4'h5}
  };

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] prev;

    // Reset held with inputs high: outputs must stay at RESET_VALUE.
    rst     = 1'b1;
    data_in = 4'hF;
    #1;
    check_quiet("rst_async", 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet($sformatf("rst_hold%0d", i), 4'h0);
    end

    // First edge after release: no pulse, no output change.
    rst = 1'b0;
    step();
    check_quiet("rel_edge1", 4'h0);

    // Asynchronous re-entry into reset, then settle with data_in low.
    rst = 1'b1;
    #1;
    check_quiet("rst_reenter", 4'h0);
    data_in = 4'h0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    check_quiet("settled", 4'h0);

    // Glitch on bit 1: high for 3 edges, one short of committing.
    data_in = 4'h2;
    for (int e = 1; e <= 3; e++) begin
      step();
      check_quiet($sformatf("glitch@%0d", e), 4'h0);
    end
    data_in = 4'h0;
    for (int e = 4; e <= 9; e++) begin
      step();
      check_quiet($sformatf("glitch@%0d", e), 4'h0);
    end

    // Directed step vectors.
    prev = 4'h0;
    foreach (vecs[k]) begin
      run_vec($sformatf("vec%0d", k), prev, vecs[k].din, vecs[k].r, vecs[k].f);
      prev = vecs[k].out;
    end

    // Reset mid-count: partial count discarded, full latency after release.
    data_in = 4'h1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check_quiet($sformatf("midcnt@%0d", e), 4'h0);
    end
    rst = 1'b1;
    #1;
    check_quiet("midcnt_rst", 4'h0);
    step();
    check_quiet("midcnt_hold", 4'h0);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check_eq($sformatf("midrel.out@%0d", e),  data_out, (e >= 6) ? 4'h1 : 4'h0);
      check_eq($sformatf("midrel.rise@%0d", e), rise, (e == 6) ? pulse(4'h1) : 4'h0);
      check_eq($sformatf("midrel.fall@%0d", e), fall, 4'h0);
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_resync_debounce
